// File: rtl/print_uart_tx_pkg.sv
// Shared constants for the print UART: FSM encoding, ASCII codes and hex rendering.
package print_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Index of the trailing line-feed within a printed word.
  localparam logic [3:0] LAST_CHAR  = 4'd8;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_ZERO + {4'd0, nib})
                         : (ASCII_A + {4'd0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/print_uart_tx_fifo.sv
// Synchronous word FIFO for the print path; drops pushes when full and flags it stickily.
module print_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra MSB so full and empty differ at equal low bits.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)         wr_ptr   <= wr_ptr + PTR_ONE;
      if (pop_ok)          rd_ptr   <= rd_ptr + PTR_ONE;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/print_uart_tx.sv
// Prints buffered 32-bit words as 8 hex chars + LF over an 8N1 UART line.
// state | meaning
// IDLE  | line high; pops the next word when the FIFO has one
// START | start bit (low) for one bit time
// DATA  | 8 data bits of the current char, LSB first
// STOP  | stop bit (high); then next char or back to IDLE after LF
module print_uart_tx
  import print_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          PRINT_EN,
  input  logic [31:0]                   PRINT_VAL,
  output logic                          TX,
  output logic                          BUSY,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_ONE  = 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state, state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    char_idx;
  logic [31:0]   shift_word;
  logic [31:0]   head_word;
  logic [7:0]    cur_char;
  logic          baud_done;
  logic          pop;
  logic          fifo_empty;

  print_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .push      (PRINT_EN),
    .push_data (PRINT_VAL),
    .pop       (pop),
    .pop_data  (head_word),
    .empty     (fifo_empty),
    .count     (FIFO_COUNT),
    .overflow  (OVERFLOW)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);
  // The shift register always holds the current nibble in its top four bits.
  assign cur_char  = (char_idx == LAST_CHAR) ? ASCII_LF : hex_ascii(shift_word[31:28]);
  assign BUSY      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    TX         = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        TX = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        TX = cur_char[bit_idx];
        if (baud_done && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (baud_done) state_next = (char_idx != LAST_CHAR) ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      shift_word <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE || baud_done) baud_cnt <= '0;
      else                                                   baud_cnt <= baud_cnt + BAUD_ONE;
      if (pop) begin
        shift_word <= head_word;
        char_idx   <= '0;
      end else if (state == STOP && baud_done && char_idx != LAST_CHAR) begin
        shift_word <= {shift_word[27:0], 4'h0};
        char_idx   <= char_idx + 4'd1;
      end
      if (state == START)                bit_idx <= '0;
      else if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_print_uart_tx.sv
// Bench for print_uart_tx: queue-based word model checked every cycle, plus UART decode of TX.
module tb_print_uart_tx;

  localparam int NB       = 4;
  localparam int WORD_CYC = 9 * 10 * NB;

  logic        clk;
  logic [1:0]  rst, en;
  logic [31:0] val [2];
  logic        tx8, tx4, busy8, busy4, ovf8, ovf4;
  logic [3:0]  cnt8;
  logic [2:0]  cnt4;
  logic [1:0]  tx, busy, ovf;

  int total, bad;
  bit chk_on;

  logic [31:0] m_q  [2][$];
  bit          m_act [2];
  int          m_off [2];
  logic [31:0] m_cur [2];
  bit          m_ovf [2];

  logic [7:0]  rx_q  [2][$];
  bit          rx_on [2];
  int          rx_cnt [2];
  logic [7:0]  rx_b  [2];

  assign tx   = {tx4, tx8};
  assign busy = {busy4, busy8};
  assign ovf  = {ovf4, ovf8};

  print_uart_tx #(.CLKS_PER_BIT(NB), .FIFO_DEPTH(8)) dut8 (
    .CLK(clk), .RESET(rst[0]), .PRINT_EN(en[0]), .PRINT_VAL(val[0]),
    .TX(tx8), .BUSY(busy8), .OVERFLOW(ovf8), .FIFO_COUNT(cnt8));

  print_uart_tx #(.CLKS_PER_BIT(NB), .FIFO_DEPTH(4)) dut4 (
    .CLK(clk), .RESET(rst[1]), .PRINT_EN(en[1]), .PRINT_VAL(val[1]),
    .TX(tx4), .BUSY(busy4), .OVERFLOW(ovf4), .FIFO_COUNT(cnt4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected line level for a word at a given cycle offset into its 360-cycle frame.
  function automatic logic exp_tx(input logic [31:0] w, input int off);
    int ci, b, nib;
    logic [7:0] ch;
    ci = off / (10 * NB);
    b  = (off % (10 * NB)) / NB;
    if (ci == 8) ch = 8'h0A;
    else begin
      nib = int'((w >> (28 - 4 * ci)) & 32'hF);
      ch  = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
    end
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bytes(input int d, input int off, input string nm, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (off + i < rx_q[d].size()) chk(nm, 32'(rx_q[d][off+i]), 32'(s[i]));
      else                          chk(nm, 32'hFFFF_FFFF, 32'(s[i]));
    end
  endtask

  initial begin
    int busy_n, ones;
    int exp_c [6];
    int exp_o [6];
    int exp_t [6];
    exp_c = '{1, 1, 2, 3, 4, 4};
    exp_o = '{0, 0, 0, 0, 0, 1};
    exp_t = '{1, 0, 0, 0, 0, 0};
    rst = 2'b11; en = 2'b00; val[0] = '0; val[1] = '0;
    chk_on = 1'b0; total = 0; bad = 0;

    fork
      forever begin : model
        int  pre;
        bit  popw;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
          if (rst[d]) begin
            m_q[d].delete();
            m_act[d] = 1'b0; m_off[d] = 0; m_ovf[d] = 1'b0;
          end else begin
            pre  = m_q[d].size();
            popw = !m_act[d] && pre > 0;
            if (m_act[d]) begin
              if (m_off[d] == WORD_CYC - 1) m_act[d] = 1'b0;
              else                          m_off[d]++;
            end else if (popw) begin
              m_cur[d] = m_q[d].pop_front();
              m_act[d] = 1'b1; m_off[d] = 0;
            end
            if (en[d]) begin
              if (pre < depth_of(d) || popw) m_q[d].push_back(val[d]);
              else                           m_ovf[d] = 1'b1;
            end
          end
        end
      end
      forever begin : compare
        logic et;
        @(negedge clk);
        if (chk_on) begin
          for (int d = 0; d < 2; d++) begin
            et = m_act[d] ? exp_tx(m_cur[d], m_off[d]) : 1'b1;
            chk($sformatf("tx_d%0d", d), 32'(tx[d]), 32'(et));
            chk($sformatf("busy_d%0d", d), 32'(busy[d]), 32'(m_act[d] || m_q[d].size() > 0));
            chk($sformatf("ovf_d%0d", d), 32'(ovf[d]), 32'(m_ovf[d]));
            chk($sformatf("count_d%0d", d), (d == 0) ? 32'(cnt8) : 32'(cnt4), 32'(m_q[d].size()));
          end
        end
      end
      forever begin : receiver
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (rst[d] || !chk_on) rx_on[d] = 1'b0;
          else if (!rx_on[d]) begin
            if (tx[d] == 1'b0) begin rx_on[d] = 1'b1; rx_cnt[d] = 0; rx_b[d] = '0; end
          end else begin
            rx_cnt[d]++;
            if (rx_cnt[d] % NB == 2 && rx_cnt[d] >= 6 && rx_cnt[d] <= 34)
              rx_b[d][(rx_cnt[d] - 6) / NB] = tx[d];
            if (rx_cnt[d] == 38) begin
              rx_q[d].push_back(rx_b[d]);
              rx_on[d] = 1'b0;
            end
          end
        end
      end
    join_none

    tick; chk_on = 1'b1; tick; rst = 2'b00;
    chk("rst_tx8", 32'(tx8), 1);   chk("rst_busy8", 32'(busy8), 0);
    chk("rst_ovf8", 32'(ovf8), 0); chk("rst_cnt8", 32'(cnt8), 0);
    chk("rst_tx4", 32'(tx4), 1);   chk("rst_busy4", 32'(busy4), 0);
    chk("rst_ovf4", 32'(ovf4), 0); chk("rst_cnt4", 32'(cnt4), 0);

    // Long quiet period after reset
    ones = 0;
    repeat (1000) begin
      if (tx == 2'b11 && busy == 2'b00) ones++;
      tick;
    end
    chk("idle_quiet", ones, 1000);

    // Single word
    en[0] = 1'b1; val[0] = 32'hDEADBEEF; tick; en[0] = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy8) busy_n++;
      if (i == 0) begin chk("t1_cnt_push", 32'(cnt8), 1); chk("t1_tx_idle", 32'(tx8), 1); end
      if (i == 1) begin chk("t1_tx_low_after_pop", 32'(tx8), 0); chk("t1_cnt_pop", 32'(cnt8), 0); end
      tick;
    end
    chk("t1_busy_cycles", busy_n, 361);
    chk("t1_nbytes", rx_q[0].size(), 9);
    check_bytes(0, 0, "t1_bytes", "DEADBEEF\n");

    // Two words back to back, single idle cycle between them
    rx_q[0].delete();
    en[0] = 1'b1; val[0] = 32'h0; tick; val[0] = 32'h0123ABCF; tick; en[0] = 1'b0;
    for (int i = 0; i < 730; i++) begin
      if (i == 359) begin chk("t2_last_stop", 32'(tx8), 1); chk("t2_cnt_stop", 32'(cnt8), 1); end
      if (i == 360) begin chk("t2_gap_tx", 32'(tx8), 1); chk("t2_gap_busy", 32'(busy8), 1); chk("t2_gap_cnt", 32'(cnt8), 1); end
      if (i == 361) begin chk("t2_next_start", 32'(tx8), 0); chk("t2_cnt_pop", 32'(cnt8), 0); end
      tick;
    end
    chk("t2_nbytes", rx_q[0].size(), 18);
    check_bytes(0, 0, "t2_bytes", "00000000\n0123ABCF\n");

    // Full FIFO with a push landing on the IDLE pop cycle
    rx_q[0].delete();
    for (int i = 0; i < 9; i++) begin
      en[0] = 1'b1; val[0] = 32'hA0000000 + 32'(i); tick;
    end
    en[0] = 1'b0;
    chk("t4_cnt_full", 32'(cnt8), 8);
    repeat (353) tick;
    chk("t4_cnt_before", 32'(cnt8), 8); chk("t4_idle_tx", 32'(tx8), 1); chk("t4_idle_busy", 32'(busy8), 1);
    en[0] = 1'b1; val[0] = 32'hFEEDF00D; tick; en[0] = 1'b0;
    chk("t4_cnt_keep", 32'(cnt8), 8); chk("t4_no_ovf", 32'(ovf8), 0); chk("t4_start", 32'(tx8), 0);
    repeat (3300) tick;
    chk("t4_nbytes", rx_q[0].size(), 90);
    check_bytes(0, 0, "t4_first", "A0000000\n");
    check_bytes(0, 81, "t4_last", "FEEDF00D\n");
    chk("t4_no_ovf_end", 32'(ovf8), 0);

    // Depth-4 overflow with six back-to-back pushes
    for (int k = 0; k < 6; k++) begin
      en[1] = 1'b1; val[1] = 32'(k + 1); tick;
      chk($sformatf("t3_cnt_%0d", k), 32'(cnt4), 32'(exp_c[k]));
      chk($sformatf("t3_ovf_%0d", k), 32'(ovf4), 32'(exp_o[k]));
      chk($sformatf("t3_tx_%0d", k), 32'(tx4), 32'(exp_t[k]));
    end
    en[1] = 1'b0;
    repeat (1860) tick;
    chk("t3_ovf_sticky", 32'(ovf4), 1);
    chk("t3_nbytes", rx_q[1].size(), 45);
    check_bytes(1, 0, "t3_bytes", "00000001\n00000002\n00000003\n00000004\n00000005\n");

    // Reset in the middle of character 3, then a clean word
    rx_q[1].delete();
    en[1] = 1'b1; val[1] = 32'h12345678; tick; en[1] = 1'b0;
    repeat (130) tick;
    chk("t5_busy_before", 32'(busy4), 1);
    rst[1] = 1'b1; tick; rst[1] = 1'b0;
    chk("t5_tx", 32'(tx4), 1); chk("t5_busy", 32'(busy4), 0);
    chk("t5_cnt", 32'(cnt4), 0); chk("t5_ovf", 32'(ovf4), 0);
    rx_q[1].delete();
    en[1] = 1'b1; val[1] = 32'h0000000F; tick; en[1] = 1'b0;
    repeat (380) tick;
    chk("t5_nbytes", rx_q[1].size(), 9);
    check_bytes(1, 0, "t5_bytes", "0000000F\n");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Consumer end of the core's print interface: takes the single-cycle PRINT_EN/PRINT_VAL pulses that DataMemory emits on a print store.
- Buffers the 32-bit values in a small FIFO.
- Renders each value as 8 uppercase hex ASCII characters plus LF, then shifts them out on an 8N1 UART TX line.
- Sits at top level beside CorePipe so simulation and FPGA builds both get console output without stalling the core.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 8, number of 32-bit print words buffered; must be a power of 2, ≥ 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- PRINT_EN  in  1  one-cycle strobe; PRINT_VAL is valid this cycle.
- PRINT_VAL  in  32  word to print.
- TX  out  1  UART serial output; idles high.
- BUSY  out  1  high while a word is being transmitted or the FIFO is non-empty.
- OVERFLOW  out  1  sticky; set when a PRINT_EN is dropped because the FIFO is full.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. Reset dominates every other input.
- Reset values: TX=1, BUSY=0, OVERFLOW=0, FIFO_COUNT=0. FIFO pointers cleared, FSM in IDLE, baud counter 0. Reset mid-character aborts it; TX is 1 on the cycle after RESET is sampled.
- FIFO push:
  - PRINT_EN=1 and not full: push; FIFO_COUNT increments on the next edge.
  - PRINT_EN=1 while full with no pop that cycle: drop the word; OVERFLOW goes 1 next cycle and holds until RESET.
  - Push and pop in the same cycle: both succeed, count unchanged, including when full.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If FIFO non-empty: pop the head word into a 32-bit shift register, set char index to 0, go to START.
  - TX=1.
- Character selection:
  - Char index 0..7 selects nibble [31-4k : 28-4k], MSB nibble first.
  - Index 8 selects LF (0x0A).
  - Nibble 0–9 maps to 0x30+n; nibble A–F maps to 0x41+(n-10).
- START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: TX = char[bit index], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP:
  - TX=1 for CLKS_PER_BIT cycles.
  - If char index < 8: increment it and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- Timing:
  - One word = 9 chars × 10 bits × CLKS_PER_BIT cycles, plus 1 IDLE cycle before the next pop.
  - Start bit begins the cycle after the pop (pop-to-TX-low latency = 1 cycle).
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads on wrap, and resets to 0 on every state entry.
- BUSY = (state != IDLE) || (FIFO_COUNT != 0).
- The FIFO wraps its pointers modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- The core is never back-pressured; overflow is the only loss mechanism.

Decomposition:
- Shared constants go in define.v:
  - UART FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - ASCII_ZERO=8'h30, ASCII_A=8'h41, ASCII_LF=8'h0A.
- One sub-module, print_fifo: synchronous FIFO with parameters WIDTH and DEPTH, push/pop, full/empty/count, and drop-on-full.
- The FSM, hex conversion and baud counter stay in print_uart_tx.

Test Plan (all with CLKS_PER_BIT=4):
1. Reset, then one pulse PRINT_VAL=0xDEADBEEF (FIFO_DEPTH=8) -> TX decodes to bytes 44 45 41 44 42 45 45 46 0A. BUSY is high for exactly 361 cycles. TX low 1 cycle after the pop.
2. PRINT_VAL=0x00000000 then 0x0123ABCF on consecutive cycles (FIFO_DEPTH=8) -> "00000000\n" then "0123ABCF\n". Exactly one IDLE cycle between the two LF stop bit and the next start bit.
3. FIFO_DEPTH=4, six back-to-back pulses with values 1..6 -> word 1 popped at cycle 1; words 2–5 stored (FIFO_COUNT=4). Word 6 dropped and OVERFLOW=1 from the next cycle. Output is "00000001\n".."00000005\n" only.
4. FIFO full (FIFO_DEPTH=8), PRINT_EN on the same cycle as the IDLE pop -> push accepted, FIFO_COUNT stays 8, OVERFLOW stays 0.
5. Assert RESET for 1 cycle in the middle of DATA for character 3 -> next cycle TX=1, BUSY=0, FIFO_COUNT=0, OVERFLOW=0. A following push of 0x0000000F prints "0000000F\n" cleanly.
6. Idle with no PRINT_EN for 1000 cycles after reset -> TX stays 1, BUSY stays 0.
